// File: rtl/sr_alu_mul_seq.sv
// Shift-and-add multiplier that borrows the core's single-cycle ALU.
// It returns the low 32 bits of op_a*op_b and runs one ADD/SHL/SHR triple for each multiplier bit.
`ifndef ALU_ADD
`define ALU_ADD  3'b000
`endif
`ifndef ALU_SRL
`define ALU_SRL  3'b010
`endif
`ifndef ALU_SLLI
`define ALU_SLLI 3'b101
`endif

module sr_alu_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        alu_sel,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  output logic [2:0]  alu_oper,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  typedef enum logic [2:0] {IDLE, ADD, SHL, SHR, DONE} state_t;

  state_t      state;
  logic [31:0] acc, mcand, mplr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand <= op_a;
          mplr  <= op_b;
          acc   <= '0;
          state <= ADD;
        end
        ADD: begin
          if (mplr[0]) acc <= alu_result;
          state <= SHL;
        end
        SHL: begin
          mcand <= alu_result;
          state <= SHR;
        end
        SHR: begin
          mplr <= alu_result;
          // The loop ends when the shifted multiplier is zero, so no iteration counter is needed.
          if (alu_zero) begin
            result <= acc;
            state  <= DONE;
          end else begin
            state  <= ADD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign alu_sel = busy && !done;

  always_comb begin
    alu_srcA = '0;
    alu_srcB = '0;
    alu_oper = `ALU_ADD;
    case (state)
      ADD: begin alu_srcA = acc;   alu_srcB = mcand; alu_oper = `ALU_ADD;  end
      SHL: begin alu_srcA = mcand; alu_srcB = 32'd1; alu_oper = `ALU_SLLI; end
      SHR: begin alu_srcA = mplr;  alu_srcB = 32'd1; alu_oper = `ALU_SRL;  end
      default: ;
    endcase
  end

endmodule

// File: doc/sr_alu_mul_seq.md
Name: sr_alu_mul_seq

Overview:
- Multi-cycle sequencer that computes the low 32 bits of an unsigned 32x32 product (RV32M MUL semantics).
- Uses only the core's shared single-cycle ALU, via the existing ALU_ADD / ALU_SLLI / ALU_SRL operations and the ALU zero flag.
- Sits beside the execute stage. While busy it owns the ALU through an external operand mux selected by alu_sel. The CPU stalls while busy.

Parameters:
- (none): width is fixed at 32 to match the ALU; operation encodings come from the shared sr_cpu.svh macros.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- op_a  input  32  multiplicand, captured when start is accepted
- op_b  input  32  multiplier, captured when start is accepted
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle pulse, high exactly in the DONE state
- result  output  32  registered product; loaded on entry to DONE, held until the next entry to DONE
- alu_sel  output  1  high means the ALU operand mux selects this block; equals busy, except low in DONE
- alu_srcA  output  32  ALU operand A
- alu_srcB  output  32  ALU operand B
- alu_oper  output  3  ALU operation code (`ALU_* macro values)
- alu_result  input  32  ALU result, combinational, same cycle
- alu_zero  input  1  ALU zero flag, same cycle

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- Reset values:
  - state = IDLE; busy = 0, done = 0, alu_sel = 0, result = 0.
  - Internal acc, mcand and mplr = 0.
  - Reset mid-operation aborts immediately. No done pulse is produced and result is not updated.
- Internal registers: acc[31:0], mcand[31:0], mplr[31:0].
- ALU drive when not in ADD, SHL or SHR: alu_srcA = 0, alu_srcB = 0, alu_oper = `ALU_ADD.
- IDLE:
  - If start: mcand <= op_a, mplr <= op_b, acc <= 0, go to ADD.
  - Otherwise stay.
- ADD:
  - Drive srcA = acc, srcB = mcand, oper = `ALU_ADD.
  - If mplr[0], then acc <= alu_result (wraps mod 2^32); otherwise acc is unchanged.
  - Always lasts exactly one cycle. Next state is SHL.
- SHL:
  - Drive srcA = mcand, srcB = 32'd1, oper = `ALU_SLLI.
  - mcand <= alu_result. Next state is SHR.
- SHR:
  - Drive srcA = mplr, srcB = 32'd1, oper = `ALU_SRL.
  - mplr <= alu_result.
  - If alu_zero, go to DONE; otherwise go to ADD.
- DONE:
  - done = 1; result holds acc, loaded on the transition into DONE.
  - Always returns to IDLE next cycle.
  - start is ignored in DONE; it is accepted again only in IDLE.
- Latency:
  - Define N = max(1, index of the most-significant set bit of op_b + 1), with N = 1 for op_b = 0.
  - If start is accepted in cycle 0, done is high in cycle 3N+1. Total occupancy is 3N+2 cycles including the return to IDLE.
  - Termination is guaranteed within 32 iterations because SRL eventually zeroes mplr; no iteration counter is required.
  - Maximum latency: done in cycle 97.
- start while busy (ADD/SHL/SHR/DONE) is ignored, with no queuing. op_a and op_b may change freely after acceptance.
- Overflow: higher product bits are discarded; no flag is provided.
- result is stable at all times except on the single edge that enters DONE.

Test Plan:
- Basic multiply: op_a = 6, op_b = 7, start in cycle 0 -> busy cycles 1..4...; done high only in cycle 10; result = 42; alu_oper sequence ADD, SLLI, SRL repeated 3 times.
- Zero multiplier: op_a = 0x12345678, op_b = 0 -> done in cycle 4, result = 0. Swap the operands (op_a = 0, op_b = 0x12345678, N = 29) -> done in cycle 88, result = 0.
- Wrap-around and maximum latency:
  - 0xFFFFFFFF x 0xFFFFFFFF -> done in cycle 97, result = 0x00000001.
  - 0x00010000 x 0x00010000 -> done in cycle 52, result = 0.
- Ignored start: pulse start with op_a = 3, op_b = 3 during cycles 2 and 6 of a 6x7 run; also pulse start during DONE -> the original run completes unchanged with result = 42, and no second done occurs. Then a start in the cycle after DONE is accepted: 3x3 -> result = 9, done 7 cycles later.
- Reset mid-operation: start 100 x 200, assert rst in cycle 5 -> next cycle busy = 0, alu_sel = 0, result = 0, no done. A fresh 5 x 5 then yields 25 in cycle 10.
- Randomized check: 1000 random op_a/op_b pairs against a reference model ((a*b) mod 2^32) with a connected ALU -> exact result match, done latency equal to 3N+1, alu_sel low whenever the block is idle or in DONE.
